risc_boot_ctrl: RTL

RISC_BOOT_CTRL -- requirements
Module: risc_boot_ctrl

---
 rtl/risc_boot_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/risc_boot_ctrl.sv
// risc_boot_ctrl: boot sequencer for a small RISC core.
// Loads a program into instruction memory over a valid/ready stream, can
// read it back, then holds the core in reset for a fixed number of cycles,
// lets it run until it halts or a cycle limit expires, and reports the result.
//
// Load handshake: a word transfers on every rising edge where ld_valid and
// ld_ready are both 1. ld_ready depends only on the FSM state, never on
// ld_valid. The producer must hold ld_data/ld_last/dump_en stable while
// ld_valid is 1, and a word not accepted is simply offered again.
//
// dbg_state exposes the FSM state for checkers:
// 0 IDLE, 1 LOAD, 2 DUMP, 3 RST, 4 RUN, 5 DONE.
module risc_boot_ctrl #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 64,
  parameter int AW         = 6,
  parameter int RST_CYCLES = 4,
  parameter int RUN_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            start,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_last,
  input  logic            dump_en,
  output logic            imem_we,
  output logic [AW-1:0]   imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            dump_valid,
  output logic [AW-1:0]   dump_addr,
  output logic [XLEN-1:0] dump_data,
  output logic            core_rst_n,
  input  logic            core_halt,
  output logic [31:0]     run_cnt,
  output logic [AW:0]     word_cnt,
  output logic            done,
  output logic            halted,
  output logic            err,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DUMP = 3'd2,
    S_RST  = 3'd3,
    S_RUN  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [31:0]   RST_LAST  = 32'(RST_CYCLES - 1);
  localparam logic [31:0]   RUN_LAST  = 32'(RUN_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   rst_cnt;

  logic accept;
  logic load_end;
  logic load_ovf;
  logic dump_end;
  logic rst_end;
  logic run_end;
  logic enter_load;

  // A word is taken whenever LOAD sees ld_valid (ld_ready is 1 in LOAD).
  assign accept   = (state == S_LOAD) && ld_valid;
  // The final memory slot ends the load even without ld_last, so no wrap.
  assign load_end = accept && (ld_last || (wr_ptr == LAST_ADDR));
  assign load_ovf = accept && !ld_last && (wr_ptr == LAST_ADDR);
  // word_cnt is at least 1 here: LOAD only exits on an accepted word.
  assign dump_end = (state == S_DUMP) && ({1'b0, rd_ptr} == (word_cnt - CNT_ONE));
  assign rst_end  = (state == S_RST) && (rst_cnt == RST_LAST);
  // Halt and the cycle limit may coincide; halted is set from core_halt alone.
  assign run_end  = (state == S_RUN) && (core_halt || (run_cnt == RUN_LAST));
  assign enter_load = (state_nxt == S_LOAD) && (state != S_LOAD);

  assign dbg_state = state;

  // State register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived outputs (memory port, dump stream, core reset).
  always_comb begin
    state_nxt  = state;
    ld_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    dump_valid = 1'b0;
    dump_addr  = '0;
    dump_data  = '0;
    core_rst_n = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        ld_ready  = 1'b1;
        imem_addr = wr_ptr;
        if (accept) begin
          imem_we    = 1'b1;
          imem_wdata = ld_data;
        end
        if (load_end) state_nxt = dump_en ? S_DUMP : S_RST;
      end
      S_DUMP: begin
        imem_addr  = rd_ptr;
        dump_valid = 1'b1;
        dump_addr  = rd_ptr;
        dump_data  = imem_rdata;
        if (dump_end) state_nxt = S_RST;
      end
      S_RST: begin
        if (rst_end) state_nxt = S_RUN;
      end
      S_RUN: begin
        core_rst_n = 1'b1;
        if (run_end) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_LOAD;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Pointers, counters and sticky status flags.
  always_ff @(posedge clk) begin
    if (!areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rst_cnt  <= '0;
      run_cnt  <= '0;
      word_cnt <= '0;
      halted   <= 1'b0;
      err      <= 1'b0;
    end else begin
      // A new session starts from a clean slate.
      if (enter_load) begin
        wr_ptr   <= '0;
        word_cnt <= '0;
        run_cnt  <= '0;
        halted   <= 1'b0;
        err      <= 1'b0;
      end
      if (accept) begin
        if (wr_ptr != LAST_ADDR) wr_ptr <= wr_ptr + ADDR_ONE;
        word_cnt <= word_cnt + CNT_ONE;
        if (load_ovf) err <= 1'b1;
      end
      // Read pointer walks during DUMP and is parked at 0 otherwise.
      if (state == S_DUMP) begin
        rd_ptr <= rd_ptr + ADDR_ONE;
      end else begin
        rd_ptr <= '0;
      end
      // Reset-pulse length counter, only live in RST.
      if (state == S_RST) begin
        rst_cnt <= rst_cnt + 32'd1;
      end else begin
        rst_cnt <= '0;
      end
      if (rst_end) run_cnt <= '0;
      // run_cnt freezes on the exit cycle, so DONE shows the last RUN count.
      if ((state == S_RUN) && !run_end) run_cnt <= run_cnt + 32'd1;
      if ((state == S_RUN) && core_halt) halted <= 1'b1;
    end
  end

endmodule
